// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request bus between the IF fetch unit (master) and imem (slave).
// A fetch completes on any cycle where imem_req and imem_ready are both high.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch controller: owns the PC, drives imem, fills IF/ID through a
// 1-entry skid buffer and applies ID redirects after the single delay slot.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_stall,
    input  logic                   i_is_branch,
    input  logic [31:0]            i_branch_pc,
    if_fetch_unit_if.master        imem,
    output logic                   o_if_id_valid,
    output logic [31:0]            o_if_id_instr,
    output logic [31:0]            o_if_id_pc,
    output logic [31:0]            o_delay_slot_pc
);

    logic        r_run;
    logic [31:0] r_pc;
    logic        r_skid_full;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic        r_pend;
    logic [31:0] r_pend_target;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_idpc;

    logic        w_req;
    logic        w_fire;
    logic        w_accept;

    assign w_req    = r_run & ~r_skid_full;
    assign w_fire   = w_req & imem.imem_ready;
    assign w_accept = r_valid & ~i_stall & i_is_branch;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    assign o_if_id_valid   = r_valid;
    assign o_if_id_instr   = r_instr;
    assign o_if_id_pc      = r_idpc;
    assign o_delay_slot_pc = r_idpc + 32'd4;

    // IF/ID register and skid buffer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run        <= 1'b0;
            r_skid_full  <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_idpc       <= '0;
        end else begin
            r_run <= 1'b1;
            if (!i_stall) begin
                if (r_skid_full) begin
                    r_valid     <= 1'b1;
                    r_instr     <= r_skid_instr;
                    r_idpc      <= r_skid_pc;
                    r_skid_full <= 1'b0;
                end else if (w_fire) begin
                    r_valid <= 1'b1;
                    r_instr <= imem.imem_rdata;
                    r_idpc  <= r_pc;
                end else begin
                    r_valid <= 1'b0;
                    r_instr <= '0;
                end
            end else if (w_fire) begin
                r_skid_full  <= 1'b1;
                r_skid_instr <= imem.imem_rdata;
                r_skid_pc    <= r_pc;
            end
        end
    end

    // PC sequencing; a redirect accepted while the delay-slot fetch is still
    // outstanding is parked in r_pend_target until that fetch completes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= RESET_PC;
            r_pend        <= 1'b0;
            r_pend_target <= '0;
        end else if (w_fire) begin
            if (r_pend) begin
                r_pc   <= r_pend_target;
                r_pend <= 1'b0;
            end else if (w_accept) begin
                r_pc <= i_branch_pc;
            end else begin
                r_pc <= r_pc + 32'd4;
            end
        end else if (w_accept) begin
            if (!w_req) begin
                r_pc <= i_branch_pc;
            end else begin
                r_pend        <= 1'b1;
                r_pend_target <= i_branch_pc;
            end
        end
    end

    a_single_pending: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(w_accept && r_pend)
    );

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- IF-stage fetch controller for the 31-instruction MIPS pipeline.
- Owns the PC and drives the instruction-memory request interface.
- Fills the IF/ID register and consumes the ID-stage redirect (is_branch, branch_pc), honouring the single architectural delay slot.
- Supplies delay_slot_pc back to the ID-stage branch logic.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hazard unit; 1 = hold IF/ID and do not advance ID
- is_branch  input  1  ID redirect request (jump, jr or taken branch), combinational from ID
- branch_pc  input  32  redirect target; valid only when is_branch=1
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address, word aligned
- imem_ready  input  1  fetch completes on the cycle imem_req & imem_ready
- imem_rdata  input  32  instruction; valid when imem_ready=1
- if_id_valid  output  1  IF/ID holds a real instruction
- if_id_instr  output  32  IF/ID instruction; 32'h0 (NOP) when invalid
- if_id_pc  output  32  IF/ID instruction address
- delay_slot_pc  output  32  if_id_pc + 4, combinational

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, imem_req=0.
  - if_id_valid=0, if_id_instr=0, if_id_pc=0.
  - Skid buffer empty, pending redirect clear.
  - An outstanding fetch is abandoned; imem must tolerate the request being dropped.
- imem_addr = pc at all times.
- imem_req = 1 whenever out of reset and the skid buffer is empty.
- While imem_req=1 and imem_ready=0, pc and imem_addr are held stable.
- Fetch completion (imem_req & imem_ready) captures {imem_rdata, pc}.
- IF/ID update, only when stall=0, in priority order:
  - Skid buffer full: load the skid entry and empty the skid. A fetch completing that same cycle is impossible because req=0.
  - Fetch completing this cycle: load it directly, valid=1.
  - Otherwise: load a bubble (valid=0, instr=0, pc unchanged).
- When stall=1, IF/ID holds its contents. A fetch completing during stall goes into the 1-entry skid buffer; req then drops until stall falls.
- Redirect capture: "accept" = if_id_valid & ~stall & is_branch, sampled at the edge where the ID instruction advances. The delay slot is the next sequential instruction after if_id_pc. It executes unconditionally and is never squashed.
- Next-pc rule:
  - Fetch completes, pending redirect set: pc <= pend_target, clear pending.
  - Fetch completes and accept this cycle: pc <= branch_pc. The completing fetch is the delay slot.
  - Fetch completes, neither of the above: pc <= pc + 4 (mod 2^32; wrap from 32'hFFFF_FFFC to 0 is allowed).
  - No fetch completes, accept, imem_req=0: the delay slot is already in the skid or moving to IF/ID, so pc <= branch_pc directly.
  - No fetch completes, accept, imem_req=1: the delay slot fetch is still pending. Latch pend_target=branch_pc, pending=1, and hold pc.
- Only one redirect can be pending; a second accept cannot occur before the delay slot completes. Verify this with an assertion.
- is_branch=0 is ignored regardless of the branch_pc value (not-taken branches fall through sequentially).
- Bit positions 1:0 of pc are never written nonzero by pc+4. A misaligned branch_pc is passed through unchecked.
- Latency:
  - Zero-wait memory, no stall: one instruction per cycle.
  - First valid IF/ID one cycle after the first ready following reset release.

Test Plan:
- Reset/sequential: RESET_PC default, imem_ready=1 constantly, stall=0 → imem_addr 0x00400000, 0x00400004, …; if_id_pc follows one cycle later; if_id_valid rises on the cycle after the first completion; delay_slot_pc = if_id_pc+4.
- Wait states: imem_ready high every 3rd cycle → imem_addr stable while waiting; IF/ID gets bubbles (valid=0, instr=0) between instructions; no address skipped.
- Taken jump: ID at 0x00400008 asserts is_branch, branch_pc=0x00400100, zero-wait → IF/ID sequence 0x00400008, 0x0040000C (delay slot), 0x00400100, 0x00400104.
- Redirect with pending delay slot: same jump but imem_ready low for 4 cycles on 0x0040000C → pending latched; after completion imem_addr=0x00400100; delay slot still delivered.
- Stall + skid + redirect: stall=1 for 3 cycles while 0x0040000C completes → skid holds it, req=0. Stall drops with a jump in ID (target 0x00400200) → IF/ID gets 0x0040000C and the next fetch address is 0x00400200, not 0x00400010.
- Reset mid-fetch: rst_n low while req=1, ready=0 → all outputs immediately at reset values; after release fetch restarts at RESET_PC with pending and skid clear.
